spi_minion_ifc: RTL and testbench
=================================

// Module: spi_minion_ifc
// PURPOSE
//  SPI minion front end between the cs/sclk/mosi/miso pads and the SPI adapter of the tapeout block.
//  Synchronizes the pad inputs into clk and deserializes each cs-framed SPI transfer into a
//  val/rdy receive stream. It also serializes the adapter's send message back onto miso.
//  Frames carry 2 flow-control bits plus NBITS payload, MSB first, SPI mode 0.
// PARAMETERS
//  NBITS  32  payload width; frame width W = NBITS+2
// PORTS
//  clk        in   1      system clock
//  reset      in   1      asynchronous, active-high reset
//  cs         in   1      SPI chip select, active low, asynchronous to clk
//  sclk       in   1      SPI clock, asynchronous to clk
//  mosi       in   1      SPI data from the master
//  miso       out  1      SPI data to the master
//  recv_msg   out  NBITS  payload received from the master
//  recv_val   out  1      recv_msg is valid
//  recv_rdy   in   1      adapter accepts recv_msg
//  send_msg   in   NBITS  payload to send to the master
//  send_val   in   1      send_msg is valid
//  send_rdy   out  1      one-cycle dequeue pulse for send_msg
//  parity     out  1      XOR of the last accepted recv_msg
//  frame_err  out  1      one-cycle pulse: frame ended with bit count != W
// BEHAVIOUR
//  - Reset (async assert) values: miso=0, recv_msg=0, recv_val=0, send_rdy=0, parity=0,
//    frame_err=0, shift reg=0, bit count=0.
//  - Synchronizers reset to idle: cs=1, sclk=0, mosi=0.
//  - cs, sclk, mosi each pass through a 2-flop synchronizer; cs and sclk edges are detected
//    on the synchronized copies.
//  - Master must hold each sclk half-period >= 4 clk cycles.
//  - Frame start (cs fall):
//      shreg <= {send_val, ~recv_val, send_msg}   // minion val bit, minion space bit, payload
//      cnt <= 0
//      snapshot adv_val = send_val and adv_spc = ~recv_val.
//  - While cs is low, on each sclk rise: shreg <= {shreg[W-2:0], mosi_s}; cnt saturates at W+1.
//  - miso = shreg[W-1], driven combinationally from the flop.
//  - miso is 0 while cs is high.
//  - Frame end (cs rise), with in-frame = shreg = {m_val, m_rdy, payload}:
//      * cnt==W and m_val & adv_spc: recv_msg <= payload, recv_val <= 1,
//        parity <= ^payload, on the next cycle.
//      * cnt==W and m_rdy & adv_val: send_rdy = 1 for exactly one cycle.
//      * cnt!=W (short, long, or empty frame): frame_err pulses 1 cycle; no other state change.
//  - recv_val stays high until a recv_val & recv_rdy cycle clears it.
//  - Clear and frame-end load in the same cycle cannot conflict: the load requires adv_spc,
//    which means recv_val was low at frame start.
//  - The adapter holds send_msg and send_val stable until send_rdy, per the val/rdy rule.
//  - sclk edges while cs is high are ignored.
//  - cs rise and sclk rise in the same cycle: the sclk rise is dropped, so cnt is not
//    incremented.
//  - Reset mid-frame aborts the frame.
//  - If cs is low when reset releases, the synchronized cs fall starts a new frame.
//    The master must restart its transfer.
//  - Latency: recv_val rises 1 clk after the synchronized cs rise, which is 3 clk after the
//    pad edge.
// STRUCTURE
//  - spi_minion_pkg:
//      frame bit-index localparams VAL_BIT=W-1, SPC_BIT=W-2;
//      counter width function $clog2(W+2).
//  - Sub-module spi_sync_edge:
//      2-flop synchronizer with registered previous value;
//      outputs sync, rise, fall;
//      reset value is a parameter;
//      three instances (cs, sclk, mosi; the mosi edge outputs are unused).
//  - Top level: shift register, counter, snapshot flops, recv holding register, output pulses.
// TESTING
//  1. Reset, idle, send_val=0, master sends {1,0,32'hDEADBEEF} (34 clocks)
//     -> master reads miso frame {0,1,32'h0}; recv_msg=DEADBEEF, recv_val=1, parity=0.
//  2. send_val=1, send_msg=32'h12345678, recv_val=0, master sends {0,1,x}
//     -> miso frame {1,1,12345678}; send_rdy one-cycle pulse; recv_val stays 0.
//  3. recv_val=1 held (recv_rdy=0), master sends {1,0,32'h1}
//     -> miso space bit=0; recv_msg unchanged; next frame still advertises space=0.
//  4. Frame of 20 sclk edges, then a frame of 35 edges
//     -> frame_err pulses once per frame; recv_val, send_rdy, parity unchanged.
//  5. Assert reset at the 10th sclk edge of a valid frame, release, send a full frame
//     -> all outputs at reset values; the second frame is accepted normally.
//  6. Back-to-back frames with recv_rdy=1 every cycle, payloads 0x1, 0x3
//     -> two accepted messages in order; parity 1 then 0.

Source files
------------

// File: rtl/spi_minion_pkg.sv
// Shared constants and helpers for the SPI minion front end.
// A frame is {val, rdy/space, payload}, transmitted MSB first.
package spi_minion_pkg;

  localparam int NBITS_DEFAULT = 32;
  localparam int W_DEFAULT     = NBITS_DEFAULT + 2;
  localparam int VAL_BIT       = W_DEFAULT - 1;
  localparam int SPC_BIT       = W_DEFAULT - 2;

  // Holds 0..W+1 so that an over-long frame can be told apart from a full one.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

  function automatic int val_bit(input int w);
    return w - 1;
  endfunction

  function automatic int spc_bit(input int w);
    return w - 2;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad input, with edge detection
// performed on the synchronized copy.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_minion_ifc.sv
// SPI minion front end: deserializes cs-framed mode-0 transfers into a val/rdy
// receive stream and shifts the adapter's send message out on miso.
module spi_minion_ifc
  import spi_minion_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic [NBITS-1:0] recv_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  input  logic [NBITS-1:0] send_msg,
  input  logic             send_val,
  output logic             send_rdy,
  output logic             parity,
  output logic             frame_err
);

  localparam int W  = NBITS + 2;
  localparam int CW = cnt_width(W);
  localparam int VB = val_bit(W);
  localparam int SB = spc_bit(W);

  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  logic [W-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic          adv_val;
  logic          adv_spc;

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .d(cs),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .d(sclk),
    .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .d(mosi),
    .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      cnt       <= '0;
      adv_val   <= 1'b0;
      adv_spc   <= 1'b0;
      recv_msg  <= '0;
      recv_val  <= 1'b0;
      parity    <= 1'b0;
      send_rdy  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only by the frame-end event.
      send_rdy  <= 1'b0;
      frame_err <= 1'b0;

      if (recv_val && recv_rdy) begin
        recv_val <= 1'b0;
      end

      // Shifting is gated by the synchronized cs, so a cs rise in the same
      // cycle as an sclk rise drops that sclk rise.
      if (cs_fall) begin
        shreg   <= {send_val, ~recv_val, send_msg};
        cnt     <= '0;
        adv_val <= send_val;
        adv_spc <= ~recv_val;
      end else if (sclk_rise && !cs_s) begin
        shreg <= {shreg[W-2:0], mosi_s};
        if (cnt != CNT_SAT) begin
          cnt <= cnt + 1'b1;
        end
      end

      // The receive load needs adv_spc, i.e. recv_val was low at frame start,
      // so it never collides with the consumer's clear above.
      if (cs_rise) begin
        if (cnt == CNT_FULL) begin
          if (shreg[VB] && adv_spc) begin
            recv_msg <= shreg[NBITS-1:0];
            recv_val <= 1'b1;
            parity   <= ^shreg[NBITS-1:0];
          end
          if (shreg[SB] && adv_val) begin
            send_rdy <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  assign miso = ~cs_s & shreg[W-1];

endmodule

// File: tb/tb_spi_minion_ifc.sv
// Self-checking bench for spi_minion_ifc: a bit-banged SPI master plus a
// transaction-level model of the minion's frame-end rules.
module tb_spi_minion_ifc;

  localparam int NB   = 32;
  localparam int W    = NB + 2;
  localparam int HALF = 6;

  logic          clk;
  logic          reset;
  logic          cs, sclk, mosi, miso;
  logic [NB-1:0] recv_msg;
  logic          recv_val, recv_rdy;
  logic [NB-1:0] send_msg;
  logic          send_val, send_rdy;
  logic          parity, frame_err;

  spi_minion_ifc #(.NBITS(NB)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .parity(parity), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int sr_cycles = 0;
  int fe_cycles = 0;
  logic [NB-1:0] got_q[$];
  logic [NB-1:0] exp_q[$];

  logic          m_rv;
  logic [NB-1:0] m_msg;
  logic          m_par;

  always @(negedge clk) begin
    if (send_rdy)  sr_cycles++;
    if (frame_err) fe_cycles++;
    if (recv_val && recv_rdy) got_q.push_back(recv_msg);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_clks(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 recv_rdy = v;
  endtask

  // Master: drive mosi while sclk is low, sample miso just before each rise.
  task automatic xfer(input logic [39:0] tx, input int n, output logic [39:0] rx);
    rx = '0;
    @(negedge clk);
    cs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < n; i++) begin
      mosi = tx[n-1-i];
      wait_clks(HALF);
      rx[n-1-i] = miso;
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(8);
  endtask

  task automatic run_frame(input string tag, input logic [39:0] tx, input int n);
    logic [39:0]   rx;
    logic [63:0]   fv, got, expv;
    logic          a_val, a_spc;
    logic [NB-1:0] pay;
    int            sr0, fe0, exp_sr, exp_fe;
    a_val  = send_val;
    a_spc  = ~m_rv;
    fv     = 64'({a_val, a_spc, send_msg});
    sr0    = sr_cycles;
    fe0    = fe_cycles;
    exp_sr = 0;
    exp_fe = 0;
    xfer(tx, n, rx);
    if (n <= W) begin
      got  = 64'(rx);
      expv = fv >> (W - n);
    end else begin
      got  = 64'(rx >> (n - W));
      expv = fv;
    end
    check({tag, "/miso"}, got, expv);
    if (n == W) begin
      pay = tx[NB-1:0];
      if (tx[W-1] && a_spc) begin
        m_rv  = 1'b1;
        m_msg = pay;
        m_par = ^pay;
        if (recv_rdy) begin
          exp_q.push_back(pay);
          m_rv = 1'b0;
        end
      end
      if (tx[W-2] && a_val) exp_sr = 1;
    end else begin
      exp_fe = 1;
    end
    check({tag, "/send_rdy_cycles"}, 64'(sr_cycles - sr0), 64'(exp_sr));
    check({tag, "/frame_err_cycles"}, 64'(fe_cycles - fe0), 64'(exp_fe));
    check({tag, "/recv_val"}, 64'(recv_val), 64'(m_rv));
    check({tag, "/recv_msg"}, 64'(recv_msg), 64'(m_msg));
    check({tag, "/parity"}, 64'(parity), 64'(m_par));
    check({tag, "/miso_idle"}, 64'(miso), 64'(0));
    if (exp_sr != 0) send_val = 1'b0;
  endtask

  task automatic drain();
    set_rdy(1'b1);
    set_rdy(1'b0);
    if (m_rv) begin
      exp_q.push_back(m_msg);
      m_rv = 1'b0;
    end
    wait_clks(2);
    check("drain/recv_val", 64'(recv_val), 64'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "/miso"}, 64'(miso), 64'(0));
    check({tag, "/recv_msg"}, 64'(recv_msg), 64'(0));
    check({tag, "/recv_val"}, 64'(recv_val), 64'(0));
    check({tag, "/send_rdy"}, 64'(send_rdy), 64'(0));
    check({tag, "/parity"}, 64'(parity), 64'(0));
    check({tag, "/frame_err"}, 64'(frame_err), 64'(0));
  endtask

  initial begin
    logic [39:0] tx;
    int          n, fe0, sr0;

    cs = 1'b1; sclk = 1'b0; mosi = 1'b0; reset = 1'b1;
    recv_rdy = 1'b0; send_val = 1'b0; send_msg = '0;
    m_rv = 1'b0; m_msg = '0; m_par = 1'b0;
    wait_clks(3);
    check_reset_values("reset");
    reset = 1'b0;
    wait_clks(4);

    // 1: master posts DEADBEEF into an idle minion
    run_frame("t1", {6'b0, 2'b10, 32'hDEADBEEF}, W);
    check("t1/recv_msg_const", 64'(recv_msg), 64'h0000_0000_DEAD_BEEF);
    drain();

    // 2: minion sends 12345678, master has space
    send_msg = 32'h12345678;
    send_val = 1'b1;
    run_frame("t2", {6'b0, 2'b01, 32'($urandom)}, W);

    // 3: recv_val held high blocks further loads and advertises no space
    run_frame("t3a", {6'b0, 2'b10, 32'h1}, W);
    run_frame("t3b", {6'b0, 2'b10, 32'h2}, W);
    run_frame("t3c", {6'b0, 2'b00, 32'($urandom)}, W);
    drain();

    // 4: short and long frames
    run_frame("t4_short", {8'($urandom), 32'($urandom)}, 20);
    run_frame("t4_long", {8'($urandom), 32'($urandom)}, 35);

    // 5: reset in the middle of a frame
    send_val = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 10; i++) begin
      mosi = 1'($urandom_range(0, 1));
      wait_clks(HALF);
      sclk = 1'b1;
      wait_clks(HALF);
      sclk = 1'b0;
    end
    fe0 = fe_cycles;
    sr0 = sr_cycles;
    reset = 1'b1;
    m_rv = 1'b0; m_msg = '0; m_par = 1'b0;
    wait_clks(2);
    check_reset_values("t5_mid");
    cs = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    wait_clks(6);
    check("t5/no_frame_err", 64'(fe_cycles - fe0), 64'(0));
    check("t5/no_send_rdy", 64'(sr_cycles - sr0), 64'(0));
    run_frame("t5_after", {6'b0, 2'b10, 32'hCAFE_F00D}, W);
    drain();

    // 6: back-to-back frames with the adapter always ready
    set_rdy(1'b1);
    run_frame("t6a", {6'b0, 2'b10, 32'h1}, W);
    run_frame("t6b", {6'b0, 2'b10, 32'h3}, W);
    set_rdy(1'b0);

    // Randomized frames
    for (int k = 0; k < 10; k++) begin
      if (!send_val) begin
        send_val = 1'($urandom_range(0, 1));
        send_msg = 32'($urandom);
      end
      n  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 35)) : W;
      tx = {6'b0, 2'($urandom_range(0, 3)), 32'($urandom)};
      run_frame($sformatf("rnd%0d", k), tx, n);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    check("acc/count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("acc/msg%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
